cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter INDEX_W, default 2, meaning the line-index width; there are 2**INDEX_W lines and TAG_W = 5-INDEX_W.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req, input, 1 bit: access request, sampled only in IDLE.
REQ-005 SHALL have port cpu_wren, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port cpu_addr, input, 5 bits: byte address {tag, index}.
REQ-007 SHALL have port cpu_wdata, input, 8 bits: write data.
REQ-008 SHALL have port cpu_rdata, output, 8 bits: read data, valid while cpu_ready=1.
REQ-009 SHALL have port cpu_ready, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port cpu_hit, output, 1 bit: qualifies cpu_ready; 1 = access hit.
REQ-011 SHALL have port mem_address, output, 5 bits: backing-memory address.
REQ-012 SHALL have port mem_data, output, 8 bits: backing-memory write data.
REQ-013 SHALL have port mem_wren, output, 1 bit: backing-memory write enable; memory writes on negedge.
REQ-014 SHALL have port mem_q, input, 8 bits: backing-memory read data, registered by memory on posedge.
REQ-015 SHALL have ports hit_count and miss_count, output, 8 bits each: statistics (see Configuration).

Function
REQ-016 SHALL be direct-mapped and write-back/write-allocate; each line holds valid, dirty, tag[TAG_W] and data[8].
REQ-017 SHALL use states IDLE, COMPARE, WRITEBACK, ALLOCATE, ALLOC_WAIT, DONE.
REQ-018 IDLE: on cpu_req=1, SHALL latch cpu_addr/cpu_wdata/cpu_wren and go to COMPARE; otherwise stay.
REQ-019 COMPARE: hit = valid && tag match; read hit -> DONE; write hit writes data, sets dirty -> DONE; miss with valid&&dirty victim -> WRITEBACK; otherwise -> ALLOCATE.
REQ-020 WRITEBACK: SHALL drive mem_address={victim tag,index}, mem_data=victim data, mem_wren=1 for exactly one cycle, clear dirty -> ALLOCATE.
REQ-021 ALLOCATE: SHALL drive mem_address=latched address, mem_wren=0 -> ALLOC_WAIT.
REQ-022 ALLOC_WAIT: SHALL fill the line from mem_q with valid=1, tag set, dirty=0; on a write, SHALL merge cpu_wdata and set dirty=1 -> DONE.
REQ-023 DONE: SHALL assert cpu_ready=1 for one cycle with cpu_rdata=line data and cpu_hit as determined in COMPARE -> IDLE.
REQ-024 Latency req-accept to cpu_ready: hit 3 cycles, clean miss 5, dirty miss 6.
REQ-025 mem_address, mem_data and mem_wren SHALL be decoded from registered state only, stable for the whole cycle; mem_wren=0 in every state except WRITEBACK.
REQ-026 cpu_req outside IDLE SHALL be ignored; a request held high in DONE is accepted in the following IDLE cycle.
REQ-027 Two consecutive accesses to the same address SHALL have the second access hit.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, clear all valid/dirty bits, and set cpu_ready=0, cpu_hit=0, cpu_rdata=0, mem_wren=0, mem_address=0, mem_data=0, hit_count=0, miss_count=0.
REQ-029 Reset during WRITEBACK/ALLOCATE/ALLOC_WAIT SHALL abort the access with no cpu_ready pulse; dirty data is lost.

Configuration
REQ-030 With CACHE_STATS_EN defined, hit_count/miss_count SHALL increment on each DONE by outcome, saturating at 8'hFF; without it both SHALL be tied to 0.

Verification
REQ-031 Memory preloaded mem[i]=8'h10+i; read 5'h05 -> cpu_ready on cycle 5, cpu_hit=0, cpu_rdata=8'h15; repeat -> cycle 3, cpu_hit=1, 8'h15.
REQ-032 Write 8'hAA to 5'h06 then read 5'h06 -> write miss (ready cycle 5), read hit returns 8'hAA, mem_wren never asserted.
REQ-033 After REQ-032, read 5'h0E (same index 2'b10) -> one mem_wren cycle with address 5'h06/data 8'hAA, ready on cycle 6, cpu_rdata=8'h1E.
REQ-034 Assert reset_n=0 during ALLOCATE -> mem_wren=0, no cpu_ready; after release, read 5'h05 misses.
REQ-035 With CACHE_STATS_EN, 300 repeated reads to 5'h01 -> miss_count=1, hit_count=8'hFF.

Source files
------------

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//   Direct-mapped, write-back / write-allocate cache between a CPU port and
//   a byte-wide backing memory. 5-bit byte address split as {tag, index};
//   2**INDEX_W lines, each holding valid, dirty, tag and one data byte.
//
//   Optional feature (macro CACHE_STATS_EN): hit/miss statistics counters,
//   saturating at 8'hFF. Without the macro both counters are tied to 0.
//
// Ports
//   clock, reset_n      : clock (posedge) and asynchronous active-low reset
//   cpu_req             : access request, sampled only in IDLE
//   cpu_wren            : 1 = write, 0 = read
//   cpu_addr[4:0]       : byte address {tag, index}
//   cpu_wdata[7:0]      : write data
//   cpu_rdata[7:0]      : read data, valid while cpu_ready = 1
//   cpu_ready           : one-cycle completion pulse
//   cpu_hit             : qualifies cpu_ready, 1 = access hit
//   mem_address[4:0]    : backing-memory address
//   mem_data[7:0]       : backing-memory write data
//   mem_wren            : backing-memory write enable (memory writes on negedge)
//   mem_q[7:0]          : backing-memory read data (registered by memory)
//   hit_count[7:0]      : number of hits  (CACHE_STATS_EN only)
//   miss_count[7:0]     : number of misses (CACHE_STATS_EN only)
// ---------------------------------------------------------------------------
module cache_controller #(
    parameter int INDEX_W = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_wren,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ready,
    output logic       cpu_hit,
    output logic [4:0] mem_address,
    output logic [7:0] mem_data,
    output logic       mem_wren,
    input  logic [7:0] mem_q,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
);

    localparam int TAG_W = 5 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE, COMPARE, WRITEBACK, ALLOCATE, ALLOC_WAIT, DONE
    } state_t;

    state_t             state;
    logic               req_wren;
    logic [4:0]         req_addr;
    logic [7:0]         req_wdata;
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [7:0]         data_mem [LINES];

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   line_tag;
    logic [7:0]         line_data;
    logic               line_hit;
    logic               line_we;
    logic               tag_we;
    logic [7:0]         line_wdata;

    assign req_index = req_addr[INDEX_W-1:0];
    assign req_tag   = req_addr[4:INDEX_W];
    assign line_tag  = tag_mem[req_index];
    assign line_data = data_mem[req_index];
    assign line_hit  = valid[req_index] && (line_tag == req_tag);

    // Line write port: write hits in COMPARE, fills (with optional merge)
    // in ALLOC_WAIT where mem_q already holds the requested byte.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        line_we    = 1'b0;
        tag_we     = 1'b0;
        line_wdata = req_wdata;
        if (state == COMPARE && line_hit && req_wren) begin
            line_we = 1'b1;
        end else if (state == ALLOC_WAIT) begin
            line_we    = 1'b1;
            tag_we     = 1'b1;
            line_wdata = req_wren ? req_wdata : mem_q;
        end
    end

    // NOTE: tag/data storage has no reset; the valid bits make stale contents unreachable.
    always_ff @(posedge clock) begin
        if (line_we) data_mem[req_index] <= line_wdata;
        if (tag_we)  tag_mem[req_index]  <= req_tag;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_wren    <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            valid       <= '0;
            dirty       <= '0;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            cpu_hit     <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            mem_wren  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_wren  <= cpu_wren;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (line_hit) begin
                        cpu_hit   <= 1'b1;
                        cpu_rdata <= req_wren ? req_wdata : line_data;
                        cpu_ready <= 1'b1;
                        if (req_wren) dirty[req_index] <= 1'b1;
                        state     <= DONE;
                    end else if (valid[req_index] && dirty[req_index]) begin
                        // Victim write is set up here so mem_* are stable for
                        // the whole WRITEBACK cycle.
                        cpu_hit     <= 1'b0;
                        mem_address <= {line_tag, req_index};
                        mem_data    <= line_data;
                        mem_wren    <= 1'b1;
                        state       <= WRITEBACK;
                    end else begin
                        cpu_hit     <= 1'b0;
                        mem_address <= req_addr;
                        state       <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    dirty[req_index] <= 1'b0;
                    mem_address      <= req_addr;
                    state            <= ALLOCATE;
                end
                ALLOCATE: begin
                    state <= ALLOC_WAIT;
                end
                ALLOC_WAIT: begin
                    valid[req_index] <= 1'b1;
                    dirty[req_index] <= req_wren;
                    cpu_rdata        <= line_wdata;
                    cpu_ready        <= 1'b1;
                    state            <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == DONE) begin
            if (cpu_hit && hit_count != 8'hFF)
                hit_count <= hit_count + 8'd1;
            else if (!cpu_hit && miss_count != 8'hFF)
                miss_count <= miss_count + 8'd1;
        end
    end
`else
    assign hit_count  = 8'h00;
    assign miss_count = 8'h00;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
//   Directed self-checking bench for cache_controller. A behavioural backing
//   memory (preloaded mem[i] = 8'h10 + i, registered read, negedge write)
//   sits on the memory port. Each access pushes its expected rdata / hit /
//   latency onto a scoreboard queue; the entry is popped when cpu_ready is
//   seen and compared. Statistics expectations follow CACHE_STATS_EN.
// ---------------------------------------------------------------------------
module tb_cache_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_req;
    logic       cpu_wren;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ready;
    logic       cpu_hit;
    logic [4:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic [7:0] mem_q;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    cache_controller #(.INDEX_W(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_wren    (cpu_wren),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .cpu_hit     (cpu_hit),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clock = ~clock;

    // Backing memory and bus monitors
    logic [7:0] mem [32];
    int         wr_count    = 0;
    int         ready_count = 0;
    logic [4:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
    end

    always @(posedge clock) mem_q <= mem[mem_address];

    always @(negedge clock) begin
        if (mem_wren) begin
            mem[mem_address] <= mem_data;
            wr_count         <= wr_count + 1;
            last_wr_addr     <= mem_address;
            last_wr_data     <= mem_data;
        end
        if (cpu_ready) ready_count <= ready_count + 1;
    end

    // Scoreboard
    typedef struct {
        logic [7:0] rdata;
        logic       hit;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access; latency counted with the accept cycle as cycle 1.
    task automatic access(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                          input logic [7:0] er, input logic eh, input int el,
                          input string tag);
        exp_t e;
        int   cyc;
        e.rdata = er;
        e.hit   = eh;
        e.lat   = el;
        sb.push_back(e);
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_wren  = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        cyc = 1;
        do begin
            @(negedge clock);
            cyc++;
            if (cyc == 2) cpu_req = 1'b0;
        end while (!cpu_ready && cyc < 15);
        e = sb.pop_front();
        check({tag, " ready"}, 32'(cpu_ready), 32'd1);
        if (cpu_ready) begin
            check({tag, " latency"}, 32'(cyc), 32'(e.lat));
            check({tag, " rdata"}, 32'(cpu_rdata), 32'(e.rdata));
            check({tag, " hit"}, 32'(cpu_hit), 32'(e.hit));
        end
        @(negedge clock);
        check({tag, " ready pulse width"}, 32'(cpu_ready), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int rdy_snap;
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_wren  = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clock);

        // Reset state
        check("reset cpu_ready", 32'(cpu_ready), 32'd0);
        check("reset cpu_hit", 32'(cpu_hit), 32'd0);
        check("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("reset mem_wren", 32'(mem_wren), 32'd0);
        check("reset mem_address", 32'(mem_address), 32'd0);
        check("reset mem_data", 32'(mem_data), 32'd0);
        check("reset hit_count", 32'(hit_count), 32'd0);
        check("reset miss_count", 32'(miss_count), 32'd0);
        reset_n = 1'b1;

        // Clean read miss then hit on the same address
        access(1'b0, 5'h05, 8'h00, 8'h15, 1'b0, 5, "rd05 miss");
        access(1'b0, 5'h05, 8'h00, 8'h15, 1'b1, 3, "rd05 hit");

        // Write-allocate miss, then read hit; no memory write yet
        access(1'b1, 5'h06, 8'hAA, 8'hAA, 1'b0, 5, "wr06 miss");
        access(1'b0, 5'h06, 8'h00, 8'hAA, 1'b1, 3, "rd06 hit");
        check("no writeback yet", 32'(wr_count), 32'd0);

        // Conflicting read evicts the dirty line at index 2'b10
        access(1'b0, 5'h0E, 8'h00, 8'h1E, 1'b0, 6, "rd0E dirty miss");
        check("writeback count", 32'(wr_count), 32'd1);
        check("writeback address", 32'(last_wr_addr), 32'h06);
        check("writeback data", 32'(last_wr_data), 32'hAA);
        check("memory holds victim", 32'(mem[6]), 32'hAA);

        // Write hit and readback
        access(1'b1, 5'h05, 8'h55, 8'h55, 1'b1, 3, "wr05 hit");
        access(1'b0, 5'h05, 8'h00, 8'h55, 1'b1, 3, "rd05 after write");
`ifdef CACHE_STATS_EN
        check("stats hit_count", 32'(hit_count), 32'd4);
        check("stats miss_count", 32'(miss_count), 32'd3);
`else
        check("stats hit_count tied", 32'(hit_count), 32'd0);
        check("stats miss_count tied", 32'(miss_count), 32'd0);
`endif

        // Reset during ALLOCATE (clean miss to index 0: cycle 3 is ALLOCATE)
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_wren = 1'b0;
        cpu_addr = 5'h04;
        @(negedge clock);
        cpu_req = 1'b0;
        @(negedge clock);
        check("allocate address before reset", 32'(mem_address), 32'h04);
        rdy_snap = ready_count;
        reset_n  = 1'b0;
        #1;
        check("abort mem_wren", 32'(mem_wren), 32'd0);
        check("abort cpu_ready", 32'(cpu_ready), 32'd0);
        check("abort mem_address", 32'(mem_address), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("no ready after abort", 32'(ready_count), 32'(rdy_snap));
        check("no writeback during abort", 32'(wr_count), 32'd1);
        // Dirty 8'h55 was lost: memory still holds the preload value
        access(1'b0, 5'h05, 8'h00, 8'h15, 1'b0, 5, "rd05 after reset");

        // Statistics saturation with 300 reads to one address
        do_reset();
        access(1'b0, 5'h01, 8'h00, 8'h11, 1'b0, 5, "rd01 first");
        for (int i = 1; i < 300; i++)
            access(1'b0, 5'h01, 8'h00, 8'h11, 1'b1, 3, "rd01 repeat");
`ifdef CACHE_STATS_EN
        check("saturated hit_count", 32'(hit_count), 32'hFF);
        check("final miss_count", 32'(miss_count), 32'd1);
`else
        check("final hit_count tied", 32'(hit_count), 32'd0);
        check("final miss_count tied", 32'(miss_count), 32'd0);
`endif
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
